// File: rtl/acc_alu_pkg.sv
// Shared encodings for the accumulator ALU: command, opcode and FSM state codes,
// plus the two's-complement overflow helper used by the add/subtract path.
package acc_alu_pkg;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_LOAD    = 2'b01,
    CMD_PERSIST = 2'b10,
    CMD_CLEAR   = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Signed overflow from operand and result sign bits; subtraction flips the B-sign test.
  function automatic logic twos_ovf(input logic is_sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    logic ovf;
    if (is_sub) begin
      ovf = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      ovf = (a_msb == b_msb) && (r_msb != a_msb);
    end
    return ovf;
  endfunction

endpackage

// File: rtl/acc_alu_mul.sv
// Iterative shift-add multiplier: the start edge consumes multiplier bit 0, then one
// bit per cycle, so o_done is high in the WIDTH-th busy cycle with the full product.
module acc_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_p;
  logic [2*WIDTH-1:0] r_m;
  logic [WIDTH-1:0]   r_q;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  // Shift-add iteration registers; reset also aborts a multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p    <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_p    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : {(2*WIDTH){1'b0}};
      r_m    <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
      r_q    <= {1'b0, i_b[WIDTH-1:1]};
      r_cnt  <= CW'(WIDTH-1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_p   <= r_p + (r_q[0] ? r_m : {(2*WIDTH){1'b0}});
        r_m   <= r_m << 1;
        r_q   <= r_q >> 1;
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = r_p;

endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU with a valid/ready command port; single-cycle ops go through EXEC,
// multiplies through the iterative sub-module, and results are held in DONE.
module acc_alu
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       cmd,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid,
  output logic [1:0]       curr_state,
  output logic [1:0]       next_state
);

  state_e             r_state;
  state_e             w_next;
  cmd_e               w_cmd;
  op_e                w_op;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_zero;
  logic               r_ovf;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_go;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic               w_update;
  logic [WIDTH-1:0]   w_opa;
  logic [2*WIDTH-1:0] w_prod;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;

  assign w_cmd       = cmd_e'(cmd);
  assign w_op        = op_e'(op);
  assign in_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_go        = w_accept && ((w_cmd == CMD_LOAD) || (w_cmd == CMD_PERSIST));
  assign w_mul_start = w_go && (w_op == OP_MUL);
  // IDLE is only reachable through reset or CLEAR, so PERSIST there starts from zero.
  assign w_opa       = (w_cmd == CMD_LOAD) ? num1 :
                       ((r_state == ST_IDLE) ? {WIDTH{1'b0}} : r_acc);
  assign w_update    = (r_state == ST_EXEC) || ((r_state == ST_MUL) && w_mul_done);

  acc_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (w_opa),
    .i_b       (num2),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // Next-state decode; a MUL state with no multiply running falls back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          case (w_cmd)
            CMD_LOAD, CMD_PERSIST: w_next = (w_op == OP_MUL) ? ST_MUL : ST_EXEC;
            CMD_CLEAR:             w_next = ST_IDLE;
            default:               w_next = r_state;
          endcase
        end else begin
          w_next = r_state;
        end
      end
      ST_EXEC: w_next = ST_DONE;
      ST_MUL: begin
        if (w_mul_done) begin
          w_next = ST_DONE;
        end else if (w_mul_busy) begin
          w_next = ST_MUL;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Result and flag generation from the operands captured at accept.
  always_comb begin
    w_res = {WIDTH{1'b0}};
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_sh  = r_b[SHW-1:0];
    w_shl = {1'b0, r_a} << w_sh;
    w_shr = {r_a, 1'b0} >> w_sh;
    case (r_op)
      OP_ADD: begin
        {w_c, w_res} = {1'b0, r_a} + {1'b0, r_b};
        w_v = twos_ovf(1'b0, r_a[WIDTH-1], r_b[WIDTH-1], w_res[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = r_a - r_b;
        w_c   = (r_a < r_b);
        w_v   = twos_ovf(1'b1, r_a[WIDTH-1], r_b[WIDTH-1], w_res[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      // The extra bit beside the operand catches the last bit shifted out.
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_MUL: begin
        w_res = w_prod[WIDTH-1:0];
        w_c   = |w_prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        w_res = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
    endcase
  end

  // State, captured operands, accumulator and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= 1'b0;
      if (w_go) begin
        r_a  <= w_opa;
        r_b  <= num2;
        r_op <= w_op;
      end
      if (w_update) begin
        r_acc       <= w_res;
        r_carry     <= w_c;
        r_zero      <= (w_res == '0);
        r_ovf       <= w_v;
        r_out_valid <= 1'b1;
      end else if (w_accept && (w_cmd == CMD_CLEAR)) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
        r_zero  <= 1'b0;
        r_ovf   <= 1'b0;
      end
    end
  end

  assign out        = r_acc;
  assign carry      = r_carry;
  assign zero       = r_zero;
  assign overflow   = r_ovf;
  assign out_valid  = r_out_valid;
  assign curr_state = r_state;
  assign next_state = w_next;

endmodule

// File: tb/tb_acc_alu.sv
// Directed bench for acc_alu (WIDTH=8): hand-computed vectors for every op class,
// multiplier latency, ignored commands while busy, CLEAR and mid-multiply reset.
module tb_acc_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] cmd;
  logic [2:0] op;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [7:0] out;
  logic       carry;
  logic       zero;
  logic       overflow;
  logic       out_valid;
  logic [1:0] curr_state;
  logic [1:0] next_state;

  int n_cmp = 0;
  int n_err = 0;

  acc_alu #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cmd        (cmd),
    .op         (op),
    .num1       (num1),
    .num2       (num2),
    .out        (out),
    .carry      (carry),
    .zero       (zero),
    .overflow   (overflow),
    .out_valid  (out_valid),
    .curr_state (curr_state),
    .next_state (next_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for one edge, then scramble the operand inputs.
  task automatic issue(input logic [1:0] c, input logic [2:0] o,
                       input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    cmd = c;
    op = o;
    num1 = a;
    num2 = b;
    cyc();
    in_valid = 1'b0;
    cmd = 2'b00;
    op = ~o;
    num1 = ~a;
    num2 = ~b;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] e_out, input logic e_c,
                         input logic e_z, input logic e_v);
    chk({tag, "_out"}, 32'(out), 32'(e_out));
    chk({tag, "_carry"}, 32'(carry), 32'(e_c));
    chk({tag, "_zero"}, 32'(zero), 32'(e_z));
    chk({tag, "_ovf"}, 32'(overflow), 32'(e_v));
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
    chk({tag, "_state"}, 32'(curr_state), 32'd3);
  endtask

  task automatic run_exec(input string tag, input logic [1:0] c, input logic [2:0] o,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] e_out,
                          input logic e_c, input logic e_z, input logic e_v);
    issue(c, o, a, b);
    chk({tag, "_exec"}, 32'(curr_state), 32'd1);
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    cyc();
    chk_res(tag, e_out, e_c, e_z, e_v);
  endtask

  task automatic run_mul(input string tag, input logic [1:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] e_out, input logic e_c,
                         input logic send_clear);
    issue(c, 3'b111, a, b);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("%s_rdy%0d", tag, i), 32'(in_ready), 32'd0);
      chk($sformatf("%s_st%0d", tag, i), 32'(curr_state), 32'd2);
      chk($sformatf("%s_ov%0d", tag, i), 32'(out_valid), 32'd0);
      if (send_clear && i == 3) begin
        in_valid = 1'b1;
        cmd = 2'b11;
      end
      if (i == 5) begin
        in_valid = 1'b0;
        cmd = 2'b00;
      end
      cyc();
    end
    chk_res(tag, e_out, e_c, (e_out == 8'h00), 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    cmd = 2'b00;
    op = 3'b000;
    num1 = 8'h00;
    num2 = 8'h00;
    #2;
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_flags", 32'({carry, zero, overflow}), 32'd0);
    chk("rst_state", 32'(curr_state), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // First ADD, with next_state checked while the command is on the port.
    in_valid = 1'b1;
    cmd = 2'b01;
    op = 3'b000;
    num1 = 8'h57;
    num2 = 8'h1A;
    #1;
    chk("ns_exec", 32'(next_state), 32'd1);
    in_valid = 1'b0;
    run_exec("add57", 2'b01, 3'b000, 8'h57, 8'h1A, 8'h71, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("hold_out", 32'(out), 32'h71);
    chk("hold_ovalid", 32'(out_valid), 32'd0);
    chk("hold_state", 32'(curr_state), 32'd3);

    run_exec("sub_zero", 2'b10, 3'b001, 8'hAA, 8'h71, 8'h00, 1'b0, 1'b1, 1'b0);
    run_exec("sub_borrow", 2'b10, 3'b001, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_exec("add_ovf", 2'b01, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    run_exec("add_wrap", 2'b01, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    run_exec("sub_ovf", 2'b01, 3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    run_exec("and", 2'b01, 3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    run_exec("or", 2'b01, 3'b011, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0);
    run_exec("xor_zero", 2'b01, 3'b100, 8'h0F, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
    run_exec("shl1", 2'b01, 3'b101, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0);
    run_exec("shl0", 2'b01, 3'b101, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0, 1'b0);
    run_exec("shr3", 2'b01, 3'b110, 8'h85, 8'h03, 8'h10, 1'b1, 1'b0, 1'b0);

    // Multiply with a CLEAR attempted while busy, then CLEAR from DONE.
    run_mul("mul57", 2'b01, 8'h57, 8'h1A, 8'hD6, 1'b1, 1'b1);
    issue(2'b11, 3'b000, 8'h00, 8'h00);
    chk("clr_out", 32'(out), 32'h00);
    chk("clr_state", 32'(curr_state), 32'd0);
    chk("clr_ovalid", 32'(out_valid), 32'd0);
    chk("clr_flags", 32'({carry, zero, overflow}), 32'd0);
    cyc();
    chk("clr_ovalid2", 32'(out_valid), 32'd0);

    run_exec("persist_idle", 2'b10, 3'b000, 8'h33, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);
    issue(2'b00, 3'b000, 8'h00, 8'h00);
    chk("nop_state", 32'(curr_state), 32'd3);
    chk("nop_out", 32'(out), 32'h05);
    chk("nop_ovalid", 32'(out_valid), 32'd0);

    run_mul("mul0f", 2'b01, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0);
    run_mul("mul_pers", 2'b10, 8'h00, 8'h02, 8'hC2, 1'b1, 1'b0);

    // Reset asserted in the fourth multiply cycle.
    issue(2'b01, 3'b111, 8'h03, 8'h04);
    cyc();
    cyc();
    cyc();
    chk("prerst_state", 32'(curr_state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(curr_state), 32'd0);
    chk("midrst_out", 32'(out), 32'h00);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_exec("post_rst", 2'b01, 3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc();
    chk("quiet_state", 32'(curr_state), 32'd3);
    chk("quiet_out", 32'(out), 32'h02);
    chk("quiet_ovalid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acc_alu.md
ACC_ALU -- requirements
Module: acc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result width (legal 4..32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  command present.
REQ-006 SHALL have port in_ready  output  1  command accepted when in_valid && in_ready.
REQ-007 SHALL have port cmd  input  2  00 NOP, 01 LOAD (A=num1), 10 PERSIST (A=acc), 11 CLEAR.
REQ-008 SHALL have port op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-009 SHALL have ports num1 and num2  input  WIDTH  operands.
REQ-010 SHALL have port out  output  WIDTH  accumulator value.
REQ-011 SHALL have ports carry, zero and overflow  output  1 each  result flags.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse when out/flags update.
REQ-013 SHALL have ports curr_state and next_state  output  2  state register and its combinational next value.

Function
REQ-014 States SHALL be IDLE=00, EXEC=01, MUL=10, DONE=11.
REQ-015 in_ready SHALL be 1 in IDLE and DONE and 0 in EXEC and MUL; commands presented while in_ready=0 SHALL be ignored.
REQ-016 On accept, operand A (num1 for LOAD, acc for PERSIST), num2 and op SHALL be registered; later changes on num1, num2 or op SHALL have no effect.
REQ-017 Accepted LOAD/PERSIST SHALL transition: non-MUL op to EXEC, MUL to MUL.
REQ-018 Accepted NOP SHALL leave the state unchanged; accepted CLEAR SHALL zero acc and all flags and go to IDLE without an out_valid pulse.
REQ-019 EXEC SHALL last one cycle: on the next edge, acc and flags update, state goes to DONE and out_valid pulses for exactly one cycle.
REQ-020 MUL SHALL be iterative shift-add taking exactly WIDTH cycles, followed by the DONE/out_valid behaviour of REQ-019, giving out_valid WIDTH+1 cycles after accept.
REQ-021 DONE SHALL hold out and flags until the next accepted command.
REQ-022 Result SHALL be truncated to WIDTH bits; shifts SHALL use num2[SHW-1:0] as the amount and be logical.
REQ-023 carry SHALL be: ADD carry-out; SUB borrow (A<B unsigned); SHL/SHR last bit shifted out (0 if amount=0); MUL 1 if the upper WIDTH product bits are non-zero; logic ops 0.
REQ-024 overflow SHALL be two's-complement overflow for ADD/SUB and 0 otherwise; zero SHALL equal (result==0).
REQ-025 PERSIST issued from IDLE SHALL use acc=0 as A.
REQ-026 An accept in DONE SHALL occur in the same cycle that DONE is left, allowing back-to-back operations.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, acc=0, carry/zero/overflow=0, out_valid=0 and clear the multiplier counter, including mid-MUL.
REQ-028 in_ready SHALL be 1 during and after reset.

Structure
REQ-029 Package acc_alu_pkg SHALL hold the op codes, cmd codes and state encodings.
REQ-030 The iterative multiplier SHALL be a sub-module acc_alu_mul with start/busy/done and a 2*WIDTH product.

Verification (WIDTH=8)
REQ-031 Reset: rst_n=0 -> out=00, flags 0, curr_state=00, in_ready=1, out_valid=0.
REQ-032 LOAD ADD num1=57h, num2=1Ah -> next cycle out=71h, out_valid=1, carry=0, zero=0, overflow=0, curr_state=11.
REQ-033 From there, PERSIST SUB num2=71h -> out=00h, zero=1; then PERSIST SUB num2=01h -> out=FFh, carry=1.
REQ-034 LOAD MUL 57h x 1Ah -> in_ready=0 for 8 cycles, out_valid on cycle 9, out=D6h, carry=1.
REQ-035 During MUL, in_valid with CLEAR is ignored (result still D6h); CLEAR from DONE -> out=00h, state 00, no out_valid pulse.
REQ-036 rst_n pulsed low on MUL cycle 4 -> state 00 and out=00h immediately; a following LOAD ADD 01h+01h -> out=02h.
